// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: default widths, FSM state
// type and bus command encodings.
package mem_resp_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_resp_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory bus. The master drives requests, the slave (memory
// responder) returns read data and status.
interface mem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();

    logic              mem_en;
    logic              read_write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              clr_mem;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              wr_err;

    modport master (
        output mem_en, read_write, address, data_in, clr_mem,
        input  data_out, rd_valid, busy, wr_err
    );

    modport slave (
        input  mem_en, read_write, address, data_in, clr_mem,
        output data_out, rd_valid, busy, wr_err
    );

endinterface

// File: rtl/mem_array_sp.sv
// Single-port storage: synchronous write, asynchronous read. Contents are
// never reset; only the responder's clear sequence zeroes them.
module mem_array_sp #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Write port: one word per rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Clocked memory responder: 1-cycle registered reads, zero-latency writes,
// and a sequential clear-all with busy indication.
// Optional build macro MEM_RESPONDER_WPROT_EN write-protects words
// 0..WPROT_LIMIT-1 and reports rejected writes on wr_err.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WPROT_LIMIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    mem_resp_state_t   state_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;
    logic              busy_q;
    logic              wr_err_q;

    logic              access_ok;
    logic              rd_req;
    logic              wr_req;
    logic              prot_hit;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    // A bus access only counts in IDLE and loses to a simultaneous clear.
    assign access_ok = (state_q == IDLE) && !bus.clr_mem && bus.mem_en;
    assign rd_req    = access_ok && (bus.read_write == RW_READ);
    assign wr_req    = access_ok && (bus.read_write == RW_WRITE);

`ifdef MEM_RESPONDER_WPROT_EN
    localparam logic [ADDR_W:0] WPROT_LIM = WPROT_LIMIT[ADDR_W:0];
    assign prot_hit = ({1'b0, bus.address} < WPROT_LIM);
`else
    logic unused_wprot;
    assign unused_wprot = (WPROT_LIMIT != 0);
    assign prot_hit     = 1'b0;
`endif

    // Extra counter bit flags completion once the last word is written.
    assign cnt_d = cnt_q + 1'b1;

    // Storage port mux: the clear path owns the array while in CLEAR.
    // Writes are held off while reset is asserted so an abort leaves the
    // remaining words untouched.
    always_comb begin
        arr_we    = 1'b0;
        arr_addr  = bus.address;
        arr_wdata = bus.data_in;
        if (state_q == CLEAR) begin
            arr_we    = reset;
            arr_addr  = cnt_q[ADDR_W-1:0];
            arr_wdata = '0;
        end else if (wr_req && !prot_hit) begin
            arr_we    = reset;
        end
    end

    mem_array_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Control FSM with registered read data and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clr_mem) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (rd_req) begin
                        data_out_q <= arr_rdata;
                        rd_valid_q <= 1'b1;
                    end else if (wr_req && prot_hit) begin
                        wr_err_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_d;
                    if (cnt_d[ADDR_W]) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
    assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a word-array
// reference model. Protected-write expectations follow the build macro
// MEM_RESPONDER_WPROT_EN.
module tb_mem_responder;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 2**AW;
    localparam int WPL   = 16;
`ifdef MEM_RESPONDER_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    mem_responder #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WPROT_LIMIT (WPL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_dout;
    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus_if.mem_en     = 1'b0;
        bus_if.read_write = 1'b0;
        bus_if.clr_mem    = 1'b0;
    endtask

    function automatic bit is_prot(input logic [AW-1:0] a);
        return WPROT && (int'(a) < WPL);
    endfunction

    task automatic do_read(input logic [AW-1:0] a, input string tag);
        bus_if.mem_en = 1'b1; bus_if.read_write = 1'b0; bus_if.address = a;
        step();
        idle_in();
        exp_dout = ref_mem[a];
        $display("read  addr=0x%03h data_out=0x%08h rd_valid=%0b", a, bus_if.data_out, bus_if.rd_valid);
        chk({tag, "_rv"}, 32'(bus_if.rd_valid), 32'd1);
        chk({tag, "_data"}, bus_if.data_out, exp_dout);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        bus_if.mem_en = 1'b1; bus_if.read_write = 1'b1; bus_if.address = a; bus_if.data_in = d;
        step();
        idle_in();
        $display("write addr=0x%03h data=0x%08h wr_err=%0b", a, d, bus_if.wr_err);
        chk({tag, "_wr_err"}, 32'(bus_if.wr_err), 32'(is_prot(a)));
        chk({tag, "_rv"}, 32'(bus_if.rd_valid), 32'd0);
        if (!is_prot(a)) ref_mem[a] = d;
    endtask

    initial begin
        int n;
        bit done;
        idle_in();
        bus_if.address = '0;
        bus_if.data_in = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", bus_if.data_out, 32'd0);
        chk("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_wr_err", 32'(bus_if.wr_err), 32'd0);
        exp_dout = '0;
        reset = 1'b1;
        step();

        // Write top word, then clear with a simultaneous write that must drop
        do_write(12'hFFF, 32'h0000_1111, "pre_wr_fff");
        bus_if.clr_mem = 1'b1;
        bus_if.mem_en = 1'b1; bus_if.read_write = 1'b1;
        bus_if.address = 12'h010; bus_if.data_in = 32'h0000_5555;
        step();
        idle_in();
        $display("clear requested with write addr=0x010 data=0x00005555");
        chk("clr_busy_rise", 32'(bus_if.busy), 32'd1);
        n = 1; done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            if (n == 10) begin
                bus_if.mem_en = 1'b1; bus_if.read_write = 1'b0; bus_if.address = 12'hFFF;
            end
            if (n == 20) bus_if.clr_mem = 1'b1;
            step();
            if (n == 10) begin
                chk("busy_read_rv", 32'(bus_if.rd_valid), 32'd0);
                chk("busy_read_data", bus_if.data_out, exp_dout);
            end
            idle_in();
            if (bus_if.busy) n++;
            else done = 1'b1;
        end
        $display("clear finished after %0d busy cycles", n);
        chk("clr_busy_cycles", 32'(n), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        do_read(12'hFFF, "clr_rd_fff");
        do_read(12'h010, "clr_rd_010");
        do_read(12'h000, "clr_rd_000");

        // Write then read next cycle; back-to-back reads keep rd_valid high
        do_write(12'h123, 32'hDEAD_BEEF, "wr_123");
        do_read(12'h123, "rd_123");
        do_read(12'h124, "rd_124_b2b");

        // Protected boundary
        do_write(12'h00F, 32'h0000_AAAA, "wp_0f");
        do_read(12'h00F, "wp_rd_0f");
        do_write(12'h010, 32'h0000_BBBB, "wp_10");
        do_read(12'h010, "wp_rd_10");

        // Randomized traffic against the model
        for (int t = 0; t < 300; t++) begin
            logic en, rw;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            bit exp_rv, exp_err;
            en = 1'($urandom_range(0, 3) != 0);
            rw = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, DEPTH - 1));
            d  = $urandom;
            bus_if.mem_en = en; bus_if.read_write = rw; bus_if.address = a; bus_if.data_in = d;
            step();
            idle_in();
            exp_rv = 1'b0; exp_err = 1'b0;
            if (en && !rw) begin
                exp_dout = ref_mem[a];
                exp_rv = 1'b1;
            end else if (en && rw) begin
                if (is_prot(a)) exp_err = 1'b1;
                else ref_mem[a] = d;
            end
            $display("txn %0d en=%0b rw=%0b addr=0x%03h din=0x%08h dout=0x%08h", t, en, rw, a, d, bus_if.data_out);
            chk("rnd_rv", 32'(bus_if.rd_valid), 32'(exp_rv));
            chk("rnd_data", bus_if.data_out, exp_dout);
            chk("rnd_wr_err", 32'(bus_if.wr_err), 32'(exp_err));
        end

        // Reset during clear cycle 100
        do_write(12'h0C8, 32'h0000_0200, "wr_0c8");
        bus_if.clr_mem = 1'b1;
        step();
        idle_in();
        chk("clr2_busy", 32'(bus_if.busy), 32'd1);
        repeat (100) step();
        reset = 1'b0;
        #1;
        $display("reset asserted at clear cycle 100");
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_data_out", bus_if.data_out, 32'd0);
        chk("abort_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        exp_dout = '0;
        for (int i = 0; i < 100; i++) ref_mem[i] = '0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_abort_busy", 32'(bus_if.busy), 32'd0);
        do_read(12'h0C8, "abort_rd_0c8");
        do_read(12'h050, "abort_rd_050");
        do_read(12'h063, "abort_rd_063");
        do_read(12'h064, "abort_rd_064");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
